// File: rtl/fetch_predecode.sv
// fetch_predecode: IF-stage fetch PC, B-type pre-decode, and the IF/ID register that feeds the branch predictor.
// Latency: the fetched word reaches ID one cycle after fetch. branch_IF, PC_add_4 and PC_add_imm are combinational.
// Backpressure: stall holds pc, IF/ID and the counters. imem_ready=0 holds pc and injects a bubble. correct=0 squashes the fetch and redirects pc.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   stall              - hazard stall; holds pc, IF/ID and the counters
//   imem_ready         - instr_rdata is valid for pc this cycle
//   instr_rdata        - fetched word at pc
//   next_pc            - predictor PC_out, taken whenever fetch advances or redirects
//   correct            - predictor verdict for the branch in ID (0 = mispredict)
//   pc                 - fetch address
//   branch_IF          - fetched word is a live B-type branch
//   PC_add_4           - pc + 4
//   PC_add_imm         - pc + B-immediate
//   instr_ID, pc_ID    - IF/ID instruction and its pc
//   valid_ID           - IF/ID holds a real instruction
//   branch_ID          - IF/ID instruction is a branch
//   br_cnt             - saturating count of resolved branches
//   mispred_cnt        - saturating count of mispredicts
module fetch_predecode #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic [31:0]      instr_rdata,
  input  logic [31:0]      next_pc,
  input  logic             correct,
  output logic [31:0]      pc,
  output logic             branch_IF,
  output logic [31:0]      PC_add_4,
  output logic [31:0]      PC_add_imm,
  output logic [31:0]      instr_ID,
  output logic [31:0]      pc_ID,
  output logic             valid_ID,
  output logic             branch_ID,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      r_pc;
  logic [31:0]      r_instr_ID;
  logic [31:0]      r_pc_ID;
  logic             r_valid_ID;
  logic             r_branch_ID;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_is_br;
  logic             w_flush;
  logic [31:0]      w_imm;

  assign w_is_br = (instr_rdata[6:0] == 7'b1100011);
  // A stalled cycle never squashes, so correct is only meaningful when the pipe moves.
  assign w_flush = ~correct & ~stall;
  assign w_imm   = {{20{instr_rdata[31]}}, instr_rdata[7], instr_rdata[30:25],
                    instr_rdata[11:8], 1'b0};

  // The predictor services branch_IF before branch_ID, so a wrong-path fetch
  // must be masked here or it would pollute predictor state.
  assign branch_IF  = w_is_br & imem_ready & ~w_flush;
  assign PC_add_4   = r_pc + 32'd4;
  assign PC_add_imm = r_pc + w_imm;

  assign pc          = r_pc;
  assign instr_ID    = r_instr_ID;
  assign pc_ID       = r_pc_ID;
  assign valid_ID    = r_valid_ID;
  assign branch_ID   = r_branch_ID;
  assign br_cnt      = r_br_cnt;
  assign mispred_cnt = r_mispred_cnt;

  // PC and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_instr_ID  <= NOP_INSTR;
      r_pc_ID     <= 32'h0;
      r_valid_ID  <= 1'b0;
      r_branch_ID <= 1'b0;
    end else if (stall) begin
      r_pc        <= r_pc;
    end else if (w_flush) begin
      // Redirect wins even when memory is not ready.
      r_pc        <= next_pc;
      r_instr_ID  <= NOP_INSTR;
      r_pc_ID     <= r_pc;
      r_valid_ID  <= 1'b0;
      r_branch_ID <= 1'b0;
    end else if (!imem_ready) begin
      r_instr_ID  <= NOP_INSTR;
      r_pc_ID     <= r_pc;
      r_valid_ID  <= 1'b0;
      r_branch_ID <= 1'b0;
    end else begin
      r_pc        <= next_pc;
      r_instr_ID  <= instr_rdata;
      r_pc_ID     <= r_pc;
      r_valid_ID  <= 1'b1;
      r_branch_ID <= w_is_br;
    end
  end

  // Saturating performance counters; a branch in ID resolves on any non-stalled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (!stall) begin
      if (r_branch_ID && (r_br_cnt != CNT_MAX)) begin
        r_br_cnt <= r_br_cnt + CNT_ONE;
      end
      if (!correct && (r_mispred_cnt != CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_predecode.sv
// tb_fetch_predecode: scoreboard bench for fetch_predecode with a behavioural model.
// Latency: expectations are pushed on drive and popped one half-cycle later by the monitor.
// Backpressure: none; every cycle yields one expected observation.
module tb_fetch_predecode;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'hFE00_0CE3;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        imem_ready;
  logic [31:0] instr_rdata;
  logic [31:0] next_pc;
  logic        correct;

  logic [31:0] pc, PC_add_4, PC_add_imm, instr_ID, pc_ID;
  logic        branch_IF, valid_ID, branch_ID;
  logic [15:0] br_cnt, mispred_cnt;

  logic [31:0] pc_s, PC_add_4_s, PC_add_imm_s, instr_ID_s, pc_ID_s;
  logic        branch_IF_s, valid_ID_s, branch_ID_s;
  logic [1:0]  br_cnt_s, mispred_cnt_s;

  fetch_predecode dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .instr_rdata(instr_rdata), .next_pc(next_pc), .correct(correct),
    .pc(pc), .branch_IF(branch_IF), .PC_add_4(PC_add_4), .PC_add_imm(PC_add_imm),
    .instr_ID(instr_ID), .pc_ID(pc_ID), .valid_ID(valid_ID), .branch_ID(branch_ID),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  // Narrow-counter instance, used to observe saturation quickly.
  fetch_predecode #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .instr_rdata(instr_rdata), .next_pc(next_pc), .correct(correct),
    .pc(pc_s), .branch_IF(branch_IF_s), .PC_add_4(PC_add_4_s), .PC_add_imm(PC_add_imm_s),
    .instr_ID(instr_ID_s), .pc_ID(pc_ID_s), .valid_ID(valid_ID_s), .branch_ID(branch_ID_s),
    .br_cnt(br_cnt_s), .mispred_cnt(mispred_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, add4, addimm, instr, pcid;
    logic        brif, vld, brid;
    int          brc, mpc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: what the IF/ID boundary holds, in plain terms.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic        m_vld;
  logic        m_brid;
  int          m_brc;
  int          m_mpc;

  function automatic bit is_branch(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return op == 7'h63;
  endfunction

  // B-immediate as a signed integer assembled from its weighted fields.
  function automatic int b_imm(input logic [31:0] w);
    int v;
    v = 0;
    if (w[31]) v = v - 4096;
    if (w[7])  v = v + 2048;
    v = v + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
    return v;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcid = 32'h0;
    m_vld = 1'b0; m_brid = 1'b0; m_brc = 0; m_mpc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, record expectation, advance the model across the edge.
  task automatic step(input bit r, input bit s, input bit rdy, input logic [31:0] ins,
                      input logic [31:0] npc, input bit cor);
    exp_t e;
    bit   squash;
    @(posedge clk);
    #1;
    rst = r; stall = s; imem_ready = rdy; instr_rdata = ins; next_pc = npc; correct = cor;
    squash   = !cor && !s;
    e.pc     = m_pc;
    e.add4   = m_pc + 32'd4;
    e.addimm = m_pc + 32'(b_imm(ins));
    e.brif   = is_branch(ins) && rdy && !squash;
    e.instr  = m_instr;
    e.pcid   = m_pcid;
    e.vld    = m_vld;
    e.brid   = m_brid;
    e.brc    = m_brc;
    e.mpc    = m_mpc;
    sb.push_back(e);
    if (r) begin
      model_reset();
    end else if (!s) begin
      if (m_brid) m_brc++;
      if (!cor) begin
        m_mpc++;
        m_pc = npc;
        m_instr = NOP; m_vld = 1'b0; m_brid = 1'b0;
      end else if (!rdy) begin
        m_instr = NOP; m_vld = 1'b0; m_brid = 1'b0;
      end else begin
        m_pcid  = m_pc;
        m_instr = ins; m_vld = 1'b1; m_brid = is_branch(ins);
        m_pc    = npc;
      end
    end
  endtask

  // Monitor: one observation per cycle, sampled at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc",         pc,         e.pc);
      check("PC_add_4",   PC_add_4,   e.add4);
      check("PC_add_imm", PC_add_imm, e.addimm);
      check("branch_IF",  {31'b0, branch_IF}, {31'b0, e.brif});
      check("instr_ID",   instr_ID,   e.instr);
      check("valid_ID",   {31'b0, valid_ID},  {31'b0, e.vld});
      check("branch_ID",  {31'b0, branch_ID}, {31'b0, e.brid});
      if (e.vld) check("pc_ID", pc_ID, e.pcid);
      check("br_cnt",      {16'b0, br_cnt},      32'(sat(e.brc, 65535)));
      check("mispred_cnt", {16'b0, mispred_cnt}, 32'(sat(e.mpc, 65535)));
      check("s_pc",         pc_s,         e.pc);
      check("s_PC_add_4",   PC_add_4_s,   e.add4);
      check("s_PC_add_imm", PC_add_imm_s, e.addimm);
      check("s_branch_IF",  {31'b0, branch_IF_s}, {31'b0, e.brif});
      check("s_instr_ID",   instr_ID_s,   e.instr);
      check("s_valid_ID",   {31'b0, valid_ID_s},  {31'b0, e.vld});
      check("s_branch_ID",  {31'b0, branch_ID_s}, {31'b0, e.brid});
      if (e.vld) check("s_pc_ID", pc_ID_s, e.pcid);
      check("s_br_cnt",      {30'b0, br_cnt_s},      32'(sat(e.brc, 3)));
      check("s_mispred_cnt", {30'b0, mispred_cnt_s}, 32'(sat(e.mpc, 3)));
    end
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1; instr_rdata = NOP;
    next_pc = 32'h4; correct = 1'b1;
    @(posedge clk);
    model_reset();

    // Reset held, then first fetches.
    step(1, 0, 1, NOP, 32'h4, 1);
    step(1, 0, 1, NOP, 32'h4, 1);
    step(0, 0, 1, NOP, 32'h4, 1);
    step(0, 0, 1, NOP, 32'h100, 1);
    // Backward beq at 0x100.
    step(0, 0, 1, BEQ, 32'h104, 1);
    // Stall with a branch in ID and correct=0: everything holds.
    step(0, 1, 1, BEQ, 32'h300, 0);
    step(0, 1, 1, BEQ, 32'h300, 0);
    step(0, 1, 1, BEQ, 32'h300, 0);
    // Mispredict squash toward 0x200.
    step(0, 0, 1, BEQ, 32'h200, 0);
    // Memory wait.
    step(0, 0, 0, NOP, 32'h500, 1);
    step(0, 0, 0, NOP, 32'h500, 1);
    // Flush while memory not ready still redirects.
    step(0, 0, 0, BEQ, 32'h600, 0);
    // PC wrap.
    step(0, 0, 1, NOP, 32'hFFFF_FFFC, 1);
    step(0, 0, 1, BEQ, 32'h0, 1);
    // Counter saturation on the narrow instance.
    for (int i = 0; i < 5; i++) step(0, 0, 1, BEQ, 32'h40 + 32'(i * 4), 0);
    step(0, 0, 1, NOP, 32'h80, 1);

    // Randomised traffic, including resets mid-operation.
    for (int i = 0; i < 2500; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[6:0] = 7'h63;
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0,
           w, $urandom, $urandom_range(0, 7) != 0);
    end
    step(0, 0, 1, NOP, 32'h0, 1);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_predecode.md
Name: fetch_predecode

Overview:
- IF-stage block directly upstream of the branch predictor. It holds the fetch PC, pre-decodes the fetched word for conditional branches, and produces branch_IF, PC_add_4 and PC_add_imm for the predictor.
- Consumes the predictor's PC_out as next-PC and its correct flag to squash wrong-path fetch.
- Owns the IF/ID pipeline register and supplies branch_ID back to the predictor.
- Carries saturating branch and mispredict performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- CNT_W, 16, width of each performance counter
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on bubble or flush

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; holds PC and IF/ID
- imem_ready  in  1  instr_rdata valid for current pc this cycle
- instr_rdata  in  32  instruction word at pc
- next_pc  in  32  next fetch address from predictor (its PC_out)
- correct  in  1  predictor verdict for branch in ID; 0 = mispredict
- pc  out  32  current fetch address to instruction memory
- branch_IF  out  1  fetched word is a B-type branch (to predictor)
- PC_add_4  out  32  pc + 4
- PC_add_imm  out  32  pc + B-immediate
- instr_ID  out  32  IF/ID instruction
- pc_ID  out  32  IF/ID pc
- valid_ID  out  1  IF/ID holds a real instruction
- branch_ID  out  1  IF/ID instruction is a branch (to predictor)
- br_cnt  out  CNT_W  branches resolved
- mispred_cnt  out  CNT_W  mispredicts

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, instr_ID=NOP_INSTR, pc_ID=0, valid_ID=0, branch_ID=0, br_cnt=0, mispred_cnt=0. Reset mid-operation discards all in-flight state the same cycle.
- Combinational outputs:
  - PC_add_4 = pc+4, mod 2^32.
  - imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}, where i = instr_rdata.
  - PC_add_imm = pc+imm, mod 2^32; wrap-around is allowed, no overflow flag.
- Pre-decode:
  - is_br = (instr_rdata[6:0]==7'b1100011).
  - branch_IF = is_br & imem_ready & ~flush.
  - flush = ~correct & ~stall. This gating is mandatory: the predictor services branch_IF before branch_ID, so a wrong-path branch must never reach it.
- Cycle-level priority at each clk edge (not in reset):
  1. stall=1: pc, IF/ID and counters hold. correct is ignored.
  2. flush=1: pc<=next_pc (the redirect target). IF/ID gets a bubble: instr_ID=NOP_INSTR, valid_ID=0, branch_ID=0. pc_ID is don't-care, drive pc. mispred_cnt and br_cnt increment.
  3. imem_ready=0: pc holds; IF/ID gets a bubble.
  4. Otherwise: pc<=next_pc; instr_ID<=instr_rdata; pc_ID<=pc; valid_ID<=1; branch_ID<=is_br.
- br_cnt increments when branch_ID=1 & stall=0; this includes the flush case.
- Counters saturate at all-ones; no wrap.
- Fetch-to-ID latency: 1 cycle.
- branch_ID is registered only, never combinational from inputs.
- Flush with imem_ready=0 is handled as flush; the redirect still occurs.
- next_pc is taken unconditionally on advance. The block never computes next-PC itself; the predictor's PC_out already selects +4, +imm, or recovery.
- No misalignment check; pc[1:0] follows next_pc.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with imem_ready=1 and next_pc=4 -> pc=0 during reset; pc=4 after first edge; valid_ID=0 until first real fetch; counters 0.
- Backward branch: pc=0x100, instr_rdata=0xFE000CE3 (beq, imm=-8) -> branch_IF=1, PC_add_4=0x104, PC_add_imm=0x0F8. Next edge: branch_ID=1, pc_ID=0x100.
- Stall hold: assert stall for 3 cycles with correct=0 and branch_ID=1 -> pc, instr_ID, br_cnt and mispred_cnt are unchanged; branch_IF still follows instr_rdata.
- Mispredict squash: branch_ID=1, correct=0, fetched word is a branch, next_pc=0x200 -> branch_IF=0 that cycle. Next edge: pc=0x200, valid_ID=0, instr_ID=0x00000013, mispred_cnt+1, br_cnt+1.
- Memory wait: imem_ready=0 for 2 cycles -> pc held; two bubbles in ID with valid_ID=0.
- Saturation (CNT_W=2): 5 mispredicts -> mispred_cnt=3. Wrap case: pc=0xFFFFFFFC -> PC_add_4=0x0.
